// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
// The state encoding also identifies which requester owns the memory port.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int DEF_MEM_WORDS  = 4096;
  localparam int DEF_TIMEOUT    = 15;
  localparam int DEF_MAX_STREAK = 3;

  function automatic logic addr_illegal(input logic [31:0] addr, input int words);
    return addr >= 32'(words);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Priority decision between the data and fetch requesters. Data wins by default;
// after MAX_STREAK back-to-back data grants a waiting fetch is preferred.
module arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic i_data_elig,
  input  logic i_fetch_elig,
  input  logic i_grant,
  output logic o_winner
);

  localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_fetch_turn;

  assign w_fetch_turn = i_fetch_elig && (r_streak == STREAK_MAX);

  always_comb begin
    o_winner = REQ_FETCH;
    if (i_data_elig && !w_fetch_turn)
      o_winner = REQ_DATA;
  end

  // Faulted grants count too, so a stream of bad data requests cannot starve fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (i_grant) begin
      if (o_winner == REQ_DATA) begin
        if (r_streak != STREAK_MAX)
          r_streak <= r_streak + 1'b1;
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store.
// Bounds faults and memory timeouts complete as segv pulses on the owning requester.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int MAX_STREAK = DEF_MAX_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       instruction,
  output logic              instr_done,
  output logic              instr_segv,
  output logic              wait_instr,
  input  logic              ld,
  input  logic              st,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       st_data,
  output logic [31:0]       ld_data,
  output logic              data_done,
  output logic              data_segv,
  output logic              wait_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_t    r_state;
  logic [TW-1:0] r_tmo;

  logic w_can_grant;
  logic w_data_elig;
  logic w_fetch_elig;
  logic w_grant;
  logic w_winner;
  logic w_data_fault;
  logic w_fetch_fault;

  assign wait_instr = if_req & ~instr_done;
  assign wait_data  = (ld | st) & ~data_done;

  // The done cycle is dead for arbitration: the finishing requester has not yet
  // renewed, and granting the other side here would defeat the data streak.
  assign w_can_grant  = (r_state == ST_IDLE) && !instr_done && !data_done;
  assign w_data_elig  = w_can_grant && wait_data;
  assign w_fetch_elig = w_can_grant && wait_instr;
  assign w_grant      = w_data_elig || w_fetch_elig;

  assign w_data_fault  = addr_illegal(32'(data_addr), MEM_WORDS) || (ld && st);
  assign w_fetch_fault = addr_illegal(32'(if_addr), MEM_WORDS);

  arb_streak_counter #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk          (clk),
    .rst          (rst),
    .i_data_elig  (w_data_elig),
    .i_fetch_elig (w_fetch_elig),
    .i_grant      (w_grant),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      instruction <= '0;
      instr_done  <= 1'b0;
      instr_segv  <= 1'b0;
      ld_data     <= '0;
      data_done   <= 1'b0;
      data_segv   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      instr_done <= 1'b0;
      instr_segv <= 1'b0;
      data_done  <= 1'b0;
      data_segv  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            if (w_winner == REQ_DATA) begin
              if (w_data_fault) begin
                data_done <= 1'b1;
                data_segv <= 1'b1;
              end else begin
                r_state   <= ST_DATA;
                mem_req   <= 1'b1;
                mem_we    <= st;
                mem_addr  <= data_addr;
                mem_wdata <= st ? st_data : 32'd0;
                r_tmo     <= '0;
              end
            end else begin
              if (w_fetch_fault) begin
                instr_done <= 1'b1;
                instr_segv <= 1'b1;
              end else begin
                r_state   <= ST_FETCH;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= 32'd0;
                r_tmo     <= '0;
              end
            end
          end
        end
        ST_FETCH, ST_DATA: begin
          if (mem_ready || r_tmo == TMO_LAST) begin
            r_state   <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (r_state == ST_FETCH) begin
              instr_done <= 1'b1;
              instr_segv <= !mem_ready;
              if (mem_ready)
                instruction <= mem_rdata;
            end else begin
              data_done <= 1'b1;
              data_segv <= !mem_ready;
              if (mem_ready && !mem_we)
                ld_data <= mem_rdata;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported word memory between the controlpath's instruction-fetch requester and its load/store requester. Produces the wait_instr/wait_data stall signals and instr_segv/data_segv faults consumed by the controlpath. Data accesses win by default; a streak limit guarantees fetch progress. Bounds faults and memory timeouts are converted to segv completions.

Parameters:
ADDR_W, 16, word-address width
MEM_WORDS, 4096, legal addresses are 0..MEM_WORDS-1
TIMEOUT, 15, max cycles mem_req may stay high without mem_ready
MAX_STREAK, 3, consecutive data grants after which a pending fetch wins

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until instr_done
if_addr  in  ADDR_W  fetch address
instruction  out  32  registered fetched word; holds until next fetch completes
instr_done  out  1  one-cycle completion pulse, fetch
instr_segv  out  1  one-cycle fault pulse, coincident with instr_done
wait_instr  out  1  if_req & ~instr_done (combinational)
ld  in  1  load request
st  in  1  store request
data_addr  in  ADDR_W  load/store address
st_data  in  32  store data
ld_data  out  32  registered load result; holds until next load completes
data_done  out  1  one-cycle completion pulse, data
data_segv  out  1  one-cycle fault pulse, coincident with data_done
wait_data  out  1  (ld|st) & ~data_done (combinational)
mem_req  out  1  memory access strobe (registered)
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  memory address, stable while mem_req
mem_wdata  out  32  write data, stable while mem_req
mem_rdata  in  32  read data, valid with mem_ready
mem_ready  in  1  memory completes access this cycle

Behaviour:
- Reset: state IDLE; every output 0; instruction, ld_data, streak and timeout counters 0. Reset mid-access drops mem_req at that edge; no done/segv issued.
- States IDLE, FETCH, DATA.
- IDLE arbitration (per cycle): data eligible if (ld|st) & ~data_done; fetch eligible if if_req & ~instr_done. Both eligible: data wins unless streak == MAX_STREAK, then fetch wins.
- Streak: +1 per data grant (saturating at MAX_STREAK), cleared on fetch grant.
- Pre-checks at grant, no memory access: address >= MEM_WORDS, or ld&st both high -> next cycle pulse done+segv for that requester, stay IDLE. Faulted request still counts as a grant for streak.
- Legal grant: next cycle enter FETCH/DATA with mem_req=1, mem_addr latched, mem_we=st, mem_wdata=st_data (0 for fetch/load); held stable.
- In FETCH/DATA, mem_ready=1: capture mem_rdata into instruction (FETCH) or ld_data (DATA load only; stores leave ld_data unchanged); next cycle mem_req=0, pulse done, return IDLE.
- Timeout counter counts mem_req-high cycles; reaching TIMEOUT without mem_ready: drop mem_req, pulse done+segv, IDLE; captured register unchanged.
- Minimum latency request->done: 3 cycles (grant, access with ready, done). Requester must drop/renew request the cycle after done; done cycle masks its own request.
- mem_ready while IDLE is ignored.

Decomposition:
- Shared package: state encoding (IDLE/FETCH/DATA), requester-id constants, default MEM_WORDS/TIMEOUT.
- One sub-module natural: arb_streak_counter (saturating streak + priority decision). Timeout counter stays inline.

Test Plan:
- Lone fetch if_addr=0x0010, memory returns 0xDEADBEEF with zero wait states -> mem_req high 1 cycle, instr_done 3 cycles after if_req, instruction=0xDEADBEEF, wait_instr low exactly on done cycle.
- ld and if_req both held high continuously, memory always ready -> grant order D,D,D,F,D,D,D,F; streak never exceeds 3.
- st data_addr=0x0100 st_data=0x12345678 -> mem_we=1, mem_wdata=0x12345678, data_done pulses, ld_data unchanged.
- ld data_addr=4096 (MEM_WORDS) -> mem_req never asserted; data_done and data_segv pulse 2 cycles after ld; ld&st together -> same segv response.
- Fetch with mem_ready held low -> mem_req high exactly 15 cycles, then instr_done+instr_segv pulse, instruction holds prior value.
- rst asserted while mem_req high in DATA -> mem_req and all outputs 0 next edge, no data_done; subsequent ld completes normally.
